// File: rtl/adc_capture_pkg.sv
// adc_capture_pkg: shared state encoding and width constants for the stereo ADC capture buffer
package adc_capture_pkg;
  typedef enum logic [1:0] {IDLE, ARMED, CAPTURE, DONE} state_e;
  localparam int DATA_W_DEF = 24;
  localparam int PAIR_W = 2 * DATA_W_DEF;
endpackage

// File: rtl/capture_ram.sv
// capture_ram: simple dual-port sample store, registered read, no reset (maps onto EBR)
// Ports: clk; we/wa/wd write port; re/ra read port; rd registered read data (old data on same-address collision)
module capture_ram
  import adc_capture_pkg::*;
#(
  parameter int AW = 8,
  parameter int W  = PAIR_W
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] wa,
  input  logic [W-1:0]  wd,
  input  logic          re,
  input  logic [AW-1:0] ra,
  output logic [W-1:0]  rd
);
  logic [W-1:0] mem [2**AW];
  always_ff @(posedge clk) if (we) mem[wa] <= wd;
  always_ff @(posedge clk) if (re) rd <= mem[ra];
endmodule

// File: rtl/adc_capture.sv
// adc_capture: stereo ADC burst capture with optional decimation and rising-edge left-channel trigger
// Ports: clk, rst_n (async active-low); adc_l/adc_r/adc_update codec samples; arm/abort control pulses;
//        trig_en/trig_level/decim/length capture setup (latched on arm); rd_en/rd_addr -> rd_data/rd_valid
//        (1-cycle latency); busy/done/wr_count status
module adc_capture
  import adc_capture_pkg::*;
#(
  parameter int DEPTH_LOG2 = 8,
  parameter int DATA_W     = DATA_W_DEF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_W-1:0]     adc_l,
  input  logic [DATA_W-1:0]     adc_r,
  input  logic                  adc_update,
  input  logic                  arm,
  input  logic                  abort,
  input  logic                  trig_en,
  input  logic [DATA_W-1:0]     trig_level,
  input  logic [7:0]            decim,
  input  logic [DEPTH_LOG2:0]   length,
  input  logic                  rd_en,
  input  logic [DEPTH_LOG2-1:0] rd_addr,
  output logic [2*DATA_W-1:0]   rd_data,
  output logic                  rd_valid,
  output logic                  busy,
  output logic                  done,
  output logic [DEPTH_LOG2:0]   wr_count
);
  localparam logic [DEPTH_LOG2:0] DEPTH = {1'b1, {DEPTH_LOG2{1'b0}}};
  localparam logic [DEPTH_LOG2:0] INC = {{DEPTH_LOG2{1'b0}}, 1'b1};
  state_e state_q, state_d;
  logic [DEPTH_LOG2:0] len_q, len_d, wr_count_q, wr_count_d;
  logic [7:0] decim_q, decim_d, cnt_q, cnt_d;
  logic [DATA_W-1:0] level_q, level_d, prev_q, prev_d;
  logic pvld_q, pvld_d, rd_valid_q, we;
  logic [2*DATA_W-1:0] ram_rd;
  // abort beats arm; a strobe coincident with arm is dropped because arm takes the branch
  always_comb begin
    state_d = state_q;
    len_d = len_q;
    decim_d = decim_q;
    level_d = level_q;
    prev_d = prev_q;
    pvld_d = pvld_q;
    cnt_d = cnt_q;
    wr_count_d = wr_count_q;
    we = 1'b0;
    if (abort) state_d = IDLE;
    else if (arm) begin
      state_d = trig_en ? ARMED : CAPTURE;
      len_d = (length == '0 || length > DEPTH) ? DEPTH : length;
      decim_d = decim;
      level_d = trig_level;
      cnt_d = '0;
      wr_count_d = '0;
      pvld_d = 1'b0;
    end else if (adc_update) begin
      if (state_q == ARMED) begin
        prev_d = adc_l;
        pvld_d = 1'b1;
        we = pvld_q && $signed(prev_q) < $signed(level_q) && $signed(level_q) <= $signed(adc_l);
      end else if (state_q == CAPTURE) begin
        we = cnt_q == 8'd0;
        cnt_d = cnt_q - 8'd1;
      end
      if (we) begin
        wr_count_d = wr_count_q + INC;
        cnt_d = decim_q;
        state_d = (wr_count_q + INC == len_q) ? DONE : CAPTURE;
      end
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      len_q <= '0;
      decim_q <= '0;
      level_q <= '0;
      prev_q <= '0;
      pvld_q <= 1'b0;
      cnt_q <= '0;
      wr_count_q <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      len_q <= len_d;
      decim_q <= decim_d;
      level_q <= level_d;
      prev_q <= prev_d;
      pvld_q <= pvld_d;
      cnt_q <= cnt_d;
      wr_count_q <= wr_count_d;
      rd_valid_q <= rd_en;
    end
  end
  capture_ram #(.AW(DEPTH_LOG2), .W(2*DATA_W)) u_ram (
    .clk(clk),
    .we (we),
    .wa (wr_count_q[DEPTH_LOG2-1:0]),
    .wd ({adc_l, adc_r}),
    .re (rd_en),
    .ra (rd_addr),
    .rd (ram_rd)
  );
  // RAM output is unreset, so gate it to present zero whenever no read is being returned
  assign rd_data = rd_valid_q ? ram_rd : '0;
  assign rd_valid = rd_valid_q;
  assign busy = state_q == ARMED || state_q == CAPTURE;
  assign done = state_q == DONE;
  assign wr_count = wr_count_q;
endmodule

// File: tb/tb_adc_capture.sv
// tb_adc_capture: directed self-checking bench for adc_capture
module tb_adc_capture;
  logic clk = 1'b0, rst_n = 1'b0;
  logic [23:0] adc_l = '0, adc_r = '0, trig_level = '0;
  logic adc_update = 1'b0, arm = 1'b0, abort = 1'b0, trig_en = 1'b0, rd_en = 1'b0;
  logic [7:0] decim = '0, rd_addr = '0;
  logic [8:0] length = '0, wr_count;
  logic [47:0] rd_data;
  logic rd_valid, busy, done;
  int vecs = 0, errs = 0;

  adc_capture #(.DEPTH_LOG2(8), .DATA_W(24)) dut (
    .clk(clk), .rst_n(rst_n), .adc_l(adc_l), .adc_r(adc_r), .adc_update(adc_update),
    .arm(arm), .abort(abort), .trig_en(trig_en), .trig_level(trig_level), .decim(decim),
    .length(length), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data), .rd_valid(rd_valid),
    .busy(busy), .done(done), .wr_count(wr_count)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [47:0] pair(input int l);
    logic [23:0] a;
    a = 24'(l);
    return {a, -a};
  endfunction

  task automatic arm_cap(input logic te, input int lvl, input int dec, input int len);
    trig_en = te;
    trig_level = 24'(lvl);
    decim = 8'(dec);
    length = 9'(len);
    arm = 1'b1;
    tick();
    arm = 1'b0;
  endtask

  task automatic strobe_nw(input int l);
    adc_l = 24'(l);
    adc_r = 24'(-l);
    adc_update = 1'b1;
    tick();
    adc_update = 1'b0;
  endtask

  task automatic strobe(input int l);
    strobe_nw(l);
    tick();
  endtask

  task automatic rdchk(input int a, input int l, input string tag);
    rd_en = 1'b1;
    rd_addr = 8'(a);
    tick();
    rd_en = 1'b0;
    chk({tag, "_valid"}, 64'(rd_valid), 64'd1);
    chk(tag, 64'(rd_data), 64'(pair(l)));
  endtask

  initial begin
    repeat (2) tick();
    chk("rst_rd_data", 64'(rd_data), 64'd0);
    chk("rst_rd_valid", 64'(rd_valid), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_wr_count", 64'(wr_count), 64'd0);
    rst_n = 1'b1;
    tick();

    arm_cap(1'b0, 0, 0, 4);
    chk("free_busy", 64'(busy), 64'd1);
    chk("free_wc0", 64'(wr_count), 64'd0);
    for (int i = 1; i <= 3; i++) strobe(i);
    chk("free_wc3", 64'(wr_count), 64'd3);
    chk("free_notdone", 64'(done), 64'd0);
    strobe_nw(4);
    chk("free_done", 64'(done), 64'd1);
    chk("free_idle", 64'(busy), 64'd0);
    chk("free_wc4", 64'(wr_count), 64'd4);
    tick();
    strobe(5);
    strobe(6);
    chk("free_nomore", 64'(wr_count), 64'd4);
    for (int i = 0; i < 4; i++) rdchk(i, i + 1, "free_rd");

    arm_cap(1'b0, 0, 2, 3);
    for (int i = 0; i < 10; i++) strobe(i);
    chk("dec_wc", 64'(wr_count), 64'd3);
    chk("dec_done", 64'(done), 64'd1);
    rdchk(0, 0, "dec_rd0");
    rdchk(1, 3, "dec_rd1");
    rdchk(2, 6, "dec_rd2");

    strobe(50);
    chk("idle_ignore", 64'(wr_count), 64'd3);
    arm_cap(1'b1, 100, 0, 2);
    strobe(150);
    chk("trg_first", 64'(wr_count), 64'd0);
    chk("trg_armed", 64'(busy), 64'd1);
    strobe(90);
    chk("trg_below", 64'(wr_count), 64'd0);
    strobe(100);
    chk("trg_fire", 64'(wr_count), 64'd1);
    strobe(120);
    chk("trg_done", 64'(done), 64'd1);
    chk("trg_wc", 64'(wr_count), 64'd2);
    rdchk(0, 100, "trg_rd0");
    rdchk(1, 120, "trg_rd1");

    arm_cap(1'b1, -5, 0, 1);
    strobe(-20);
    strobe(-10);
    chk("neg_nofire", 64'(wr_count), 64'd0);
    strobe(3);
    chk("neg_done", 64'(done), 64'd1);
    rdchk(0, 3, "neg_rd0");

    arm_cap(1'b1, 100, 0, 4);
    repeat (3) strobe(200);
    chk("never_busy", 64'(busy), 64'd1);
    chk("never_wc", 64'(wr_count), 64'd0);
    chk("never_done", 64'(done), 64'd0);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort_busy", 64'(busy), 64'd0);

    arm_cap(1'b0, 0, 0, 0);
    for (int i = 0; i < 255; i++) strobe(i);
    chk("len0_busy", 64'(busy), 64'd1);
    chk("len0_wc255", 64'(wr_count), 64'd255);
    strobe(255);
    chk("len0_wc256", 64'(wr_count), 64'd256);
    chk("len0_done", 64'(done), 64'd1);
    strobe(999);
    chk("len0_hold", 64'(wr_count), 64'd256);
    rdchk(128, 128, "len0_rd");

    arm_cap(1'b0, 0, 0, 300);
    for (int i = 0; i < 256; i++) strobe(i + 1000);
    chk("len300_wc", 64'(wr_count), 64'd256);
    chk("len300_done", 64'(done), 64'd1);
    rdchk(255, 1255, "len300_rd");

    arm_cap(1'b0, 0, 0, 20);
    for (int i = 0; i < 10; i++) strobe(2000 + i);
    chk("rearm_wc10", 64'(wr_count), 64'd10);
    arm_cap(1'b0, 0, 0, 20);
    chk("rearm_wc0", 64'(wr_count), 64'd0);
    chk("rearm_busy", 64'(busy), 64'd1);
    strobe(7777);
    chk("rearm_wc1", 64'(wr_count), 64'd1);
    rdchk(0, 7777, "rearm_rd0");

    rd_en = 1'b1;
    rd_addr = 8'd1;
    adc_l = 24'(8888);
    adc_r = 24'(-8888);
    adc_update = 1'b1;
    tick();
    adc_update = 1'b0;
    rd_en = 1'b0;
    chk("rdw_old", 64'(rd_data), 64'(pair(2001)));
    chk("rdw_wc", 64'(wr_count), 64'd2);
    tick();
    rdchk(1, 8888, "rdw_new");

    arm = 1'b1;
    abort = 1'b1;
    tick();
    arm = 1'b0;
    abort = 1'b0;
    chk("armabort_busy", 64'(busy), 64'd0);
    chk("armabort_done", 64'(done), 64'd0);
    chk("armabort_wc", 64'(wr_count), 64'd2);

    rd_en = 1'b1;
    rd_addr = 8'd0;
    tick();
    chk("b2b_v0", 64'(rd_valid), 64'd1);
    chk("b2b_d0", 64'(rd_data), 64'(pair(7777)));
    rd_addr = 8'd1;
    tick();
    chk("b2b_v1", 64'(rd_valid), 64'd1);
    chk("b2b_d1", 64'(rd_data), 64'(pair(8888)));
    rd_addr = 8'd2;
    tick();
    chk("b2b_v2", 64'(rd_valid), 64'd1);
    chk("b2b_d2", 64'(rd_data), 64'(pair(2002)));
    rd_en = 1'b0;
    tick();
    chk("b2b_end_v", 64'(rd_valid), 64'd0);
    chk("b2b_end_d", 64'(rd_data), 64'd0);

    arm_cap(1'b0, 0, 0, 10);
    strobe(1);
    strobe(2);
    rd_en = 1'b1;
    rd_addr = 8'd0;
    tick();
    rd_en = 1'b0;
    chk("pre_rst_valid", 64'(rd_valid), 64'd1);
    chk("pre_rst_busy", 64'(busy), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("arst_busy", 64'(busy), 64'd0);
    chk("arst_wc", 64'(wr_count), 64'd0);
    chk("arst_valid", 64'(rd_valid), 64'd0);
    chk("arst_data", 64'(rd_data), 64'd0);
    chk("arst_done", 64'(done), 64'd0);
    tick();
    rst_n = 1'b1;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
